// File: rtl/text_pkg.sv
// =============================================================================
// Module   : text_pkg
// Brief    : Shared constants, op/state encodings and char filter for the text line
// Revision : 1.0
// =============================================================================
`default_nettype none

package text_pkg;

    localparam int NUM_CHARS = 40;
    localparam int CW        = 8;
    localparam int POS_W     = 6;

    typedef enum logic [1:0] {
        OP_PUT    = 2'b00,
        OP_BACK   = 2'b01,
        OP_SETPOS = 2'b10,
        OP_CLEAR  = 2'b11
    } op_t;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    // Renderer font covers NUL, digits and upper-case letters only
    function automatic logic char_supported(input logic [CW-1:0] code);
        return (code == '0) ||
               ((code >= CW'(48)) && (code <= CW'(57))) ||
               ((code >= CW'(65)) && (code <= CW'(90)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// =============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin arbiter, one-hot grant, pointer moves on advance
// Revision : 1.0
// =============================================================================
`default_nettype none

module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic r_prio_b;

    always_comb begin
        grant[0] = valid[0] & (~valid[1] | ~r_prio_b);
        grant[1] = valid[1] & (~valid[0] |  r_prio_b);
    end

    // Whoever was just served loses priority on the next contention
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio_b <= 1'b0;
        end else if (advance) begin
            r_prio_b <= grant[0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/text_buffer_ctrl.sv
// =============================================================================
// Module   : text_buffer_ctrl
// Brief    : Arbitrated shadow line buffer with cursor; commits to display on vsync
// Revision : 1.0
// =============================================================================
`default_nettype none

module text_buffer_ctrl
    import text_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vsync_start,
    input  logic                 a_valid,
    input  logic [1:0]           a_op,
    input  logic [CW-1:0]        a_data,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [1:0]           b_op,
    input  logic [CW-1:0]        b_data,
    output logic                 b_ready,
    output logic [0:CW-1]        character [0:NUM_CHARS-1],
    output logic [POS_W-1:0]     cursor,
    output logic                 busy,
    output logic                 bad_char
);

    localparam logic [POS_W-1:0] c_last_pos = POS_W'(NUM_CHARS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [POS_W-1:0]    r_clr_idx;
    logic [POS_W-1:0]    w_clr_idx_nxt;
    logic [1:0]          w_grant;
    logic                w_idle;
    logic                w_xfer;
    op_t                 w_op;
    logic [CW-1:0]       w_data;
    logic [0:CW-1]       r_shadow [0:NUM_CHARS-1];
    logic [POS_W-1:0]    r_cursor;
    logic                r_dirty;
    logic                r_bad_char;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   ({b_valid, a_valid}),
        .advance (w_xfer),
        .grant   (w_grant)
    );

    assign w_idle  = (r_state == S_IDLE);
    assign a_ready = w_idle & w_grant[0];
    assign b_ready = w_idle & w_grant[1];
    assign w_xfer  = a_ready | b_ready;
    assign w_op    = op_t'(w_grant[1] ? b_op : a_op);
    assign w_data  = w_grant[1] ? b_data : a_data;

    assign cursor   = r_cursor;
    assign busy     = (r_state == S_CLEAR);
    assign bad_char = r_bad_char;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        case (r_state)
            S_IDLE: begin
                if (w_xfer && (w_op == OP_CLEAR)) begin
                    w_state_nxt   = S_CLEAR;
                    w_clr_idx_nxt = '0;
                end
            end
            S_CLEAR: begin
                if (r_clr_idx == c_last_pos) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_clr_idx_nxt = r_clr_idx + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Commit samples the pre-edge shadow; a same-cycle write re-sets dirty after the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CHARS; k++) begin
                r_shadow[k]  <= '0;
                character[k] <= '0;
            end
            r_cursor   <= '0;
            r_dirty    <= 1'b0;
            r_bad_char <= 1'b0;
        end else begin
            r_bad_char <= 1'b0;
            if (w_idle && vsync_start && r_dirty) begin
                for (int k = 0; k < NUM_CHARS; k++) begin
                    character[k] <= r_shadow[k];
                end
                r_dirty <= 1'b0;
            end
            if (r_state == S_CLEAR) begin
                r_shadow[r_clr_idx] <= '0;
                r_dirty             <= 1'b1;
            end else if (w_xfer) begin
                case (w_op)
                    OP_PUT: begin
                        r_shadow[r_cursor] <= char_supported(w_data) ? w_data : '0;
                        r_bad_char         <= ~char_supported(w_data);
                        r_cursor           <= (r_cursor == c_last_pos) ? '0 : r_cursor + 1'b1;
                        r_dirty            <= 1'b1;
                    end
                    OP_BACK: begin
                        if (r_cursor != '0) begin
                            r_cursor                  <= r_cursor - 1'b1;
                            r_shadow[r_cursor - 1'b1] <= '0;
                            r_dirty                   <= 1'b1;
                        end
                    end
                    OP_SETPOS: begin
                        r_cursor <= (w_data > CW'(NUM_CHARS - 1)) ? c_last_pos : w_data[POS_W-1:0];
                    end
                    OP_CLEAR: begin
                        r_cursor <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_text_buffer_ctrl.sv
// =============================================================================
// Module   : tb_text_buffer_ctrl
// Brief    : Self-checking bench for text_buffer_ctrl (vector table + scoreboard)
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_text_buffer_ctrl;
    import text_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               vsync_start = 1'b0;
    logic               a_valid = 1'b0;
    logic [1:0]         a_op = 2'b00;
    logic [CW-1:0]      a_data = '0;
    logic               a_ready;
    logic               b_valid = 1'b0;
    logic [1:0]         b_op = 2'b00;
    logic [CW-1:0]      b_data = '0;
    logic               b_ready;
    logic [0:CW-1]      character [0:NUM_CHARS-1];
    logic [POS_W-1:0]   cursor;
    logic               busy;
    logic               bad_char;

    always #5 clk = ~clk;

    text_buffer_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .vsync_start (vsync_start),
        .a_valid     (a_valid),
        .a_op        (a_op),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_op        (b_op),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .character   (character),
        .cursor      (cursor),
        .busy        (busy),
        .bad_char    (bad_char)
    );

    int checks = 0;
    int errors = 0;

    int m_shadow [NUM_CHARS];
    int m_disp   [NUM_CHARS];
    int m_cursor = 0;
    bit m_dirty  = 1'b0;

    typedef struct {
        int cursor;
        bit bad;
    } exp_t;
    exp_t sb [$];

    typedef struct {
        bit  who;
        op_t op;
        int  data;
        int  exp_cursor;
        bit  exp_bad;
        bit  vs_after;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_disp(input string name);
        int bad_i;
        bad_i = -1;
        for (int k = 0; k < NUM_CHARS; k++) begin
            if ((int'(character[k]) != m_disp[k]) && (bad_i < 0)) bad_i = k;
        end
        checks++;
        if (bad_i >= 0) begin
            errors++;
            $display("FAIL %s: cell %0d got %0d expected %0d", name, bad_i,
                     int'(character[bad_i]), m_disp[bad_i]);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_CHARS; k++) begin
            m_shadow[k] = 0;
            m_disp[k]   = 0;
        end
        m_cursor = 0;
        m_dirty  = 1'b0;
    endtask

    task automatic model_apply(input op_t op, input int d);
        case (op)
            OP_PUT: begin
                if (d == 0 || (d >= 48 && d <= 57) || (d >= 65 && d <= 90)) m_shadow[m_cursor] = d;
                else m_shadow[m_cursor] = 0;
                m_cursor = (m_cursor == NUM_CHARS - 1) ? 0 : m_cursor + 1;
                m_dirty  = 1'b1;
            end
            OP_BACK: begin
                if (m_cursor != 0) begin
                    m_cursor = m_cursor - 1;
                    m_shadow[m_cursor] = 0;
                    m_dirty = 1'b1;
                end
            end
            OP_SETPOS: m_cursor = (d > NUM_CHARS - 1) ? NUM_CHARS - 1 : d;
            default: begin
                m_cursor = 0;
                for (int k = 0; k < NUM_CHARS; k++) m_shadow[k] = 0;
                m_dirty = 1'b1;
            end
        endcase
    endtask

    task automatic do_req(input bit who, input op_t op, input int d,
                          input int exp_cur, input bit exp_bad);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        if (who) begin
            b_valid = 1'b1; b_op = op; b_data = CW'(d);
        end else begin
            a_valid = 1'b1; a_op = op; a_data = CW'(d);
        end
        #1;
        while (!(who ? b_ready : a_ready) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no ready expected ready within 200 cycles");
            a_valid = 1'b0;
            b_valid = 1'b0;
            return;
        end
        model_apply(op, d);
        sb.push_back('{exp_cur, exp_bad});
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        e = sb.pop_front();
        check("cursor", int'(cursor), e.cursor);
        check("bad_char", int'(bad_char), int'(e.bad));
    endtask

    task automatic do_vsync();
        @(negedge clk);
        check_disp("pre_vsync_unchanged");
        vsync_start = 1'b1;
        @(posedge clk);
        #1;
        vsync_start = 1'b0;
        if (m_dirty) begin
            m_disp  = m_shadow;
            m_dirty = 1'b0;
        end
        check_disp("post_vsync");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl1 [2];
        vec_t tbl2 [9];
        int   cnt;

        tbl1[0] = '{1'b0, OP_PUT, 72, 1, 1'b0, 1'b0};
        tbl1[1] = '{1'b0, OP_PUT, 73, 2, 1'b0, 1'b1};

        tbl2[0] = '{1'b1, OP_SETPOS, 39,  39, 1'b0, 1'b0};
        tbl2[1] = '{1'b0, OP_PUT,    65,  0,  1'b0, 1'b0};
        tbl2[2] = '{1'b1, OP_PUT,    66,  1,  1'b0, 1'b1};
        tbl2[3] = '{1'b0, OP_BACK,   0,   0,  1'b0, 1'b0};
        tbl2[4] = '{1'b0, OP_BACK,   0,   0,  1'b0, 1'b0};
        tbl2[5] = '{1'b1, OP_PUT,    35,  1,  1'b1, 1'b0};
        tbl2[6] = '{1'b0, OP_SETPOS, 200, 39, 1'b0, 1'b0};
        tbl2[7] = '{1'b0, OP_SETPOS, 5,   5,  1'b0, 1'b0};
        tbl2[8] = '{1'b1, OP_PUT,    48,  6,  1'b0, 1'b1};

        model_reset();
        #1 rst = 1'b1;
        #1;
        check("rst_cursor", int'(cursor), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_a_ready", int'(a_ready), 0);
        check_disp("rst_display");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 2; i++) begin
            do_req(tbl1[i].who, tbl1[i].op, tbl1[i].data, tbl1[i].exp_cursor, tbl1[i].exp_bad);
            if (tbl1[i].vs_after) do_vsync();
        end
        check("hi_char0", int'(character[0]), 72);
        check("hi_char1", int'(character[1]), 73);

        // A was served last, so contention must alternate starting with B
        @(negedge clk);
        a_valid = 1'b1; a_op = OP_PUT; a_data = CW'(65);
        b_valid = 1'b1; b_op = OP_PUT; b_data = CW'(66);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("arb_a_ready", int'(a_ready), i % 2);
            check("arb_b_ready", int'(b_ready), int'((i % 2) == 0));
            model_apply(OP_PUT, ((i % 2) == 1) ? 65 : 66);
            @(posedge clk);
            @(negedge clk);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
        check("arb_cursor", int'(cursor), 6);

        for (int i = 0; i < 9; i++) begin
            do_req(tbl2[i].who, tbl2[i].op, tbl2[i].data, tbl2[i].exp_cursor, tbl2[i].exp_bad);
            if (tbl2[i].exp_bad) begin
                @(posedge clk);
                #1;
                check("bad_char_single_pulse", int'(bad_char), 0);
            end
            if (tbl2[i].vs_after) do_vsync();
        end
        check("wrap_char39", int'(character[39]), 65);
        check("bad_stored_zero", int'(character[0]), 0);
        check("char5", int'(character[5]), 48);

        do_req(1'b0, OP_CLEAR, 0, 0, 1'b0);
        cnt = 0;
        while (busy && cnt < 60) begin
            if (cnt == 9) vsync_start = 1'b1;
            @(posedge clk);
            #1;
            vsync_start = 1'b0;
            cnt++;
        end
        check("busy_cycles", cnt, 40);
        check_disp("no_commit_during_clear");
        do_vsync();
        check("cleared_char5", int'(character[5]), 0);

        do_req(1'b0, OP_PUT, 72, 1, 1'b0);
        @(negedge clk);
        a_valid = 1'b1; a_op = OP_PUT; a_data = CW'(90);
        vsync_start = 1'b1;
        #1;
        check("commit_put_ready", int'(a_ready), 1);
        m_disp = m_shadow;
        model_apply(OP_PUT, 90);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        vsync_start = 1'b0;
        check_disp("commit_with_put");
        check("put_hidden", int'(character[1]), 0);
        do_vsync();
        check("put_visible", int'(character[1]), 90);

        do_req(1'b1, OP_CLEAR, 0, 0, 1'b0);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check("midclear_busy", int'(busy), 0);
        check("midclear_cursor", int'(cursor), 0);
        check_disp("midclear_display");
        @(negedge clk) rst = 1'b0;
        do_req(1'b0, OP_PUT, 49, 1, 1'b0);
        do_vsync();
        check("after_reset_char0", int'(character[0]), 49);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/text_buffer_ctrl.md
Name: text_buffer_ctrl

Overview:
- Owns the 40-entry character line that the VGA ASCII renderer draws.
- Arbitrates character-edit requests from two requesters (A: keyboard decoder, B: game/status logic) and keeps a shadow buffer plus a cursor.
- Commits the shadow to the renderer-facing display array only at the vertical-sync boundary, so the screen never shows a half-edited line.

Parameters:
NUM_CHARS, 40, number of character cells on the line
CW, 8, character code width
POS_W, 6, cursor/position width (ceil(log2(NUM_CHARS)))

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
vsync_start  in  1  one-cycle pulse at start of vertical blank
a_valid  in  1  requester A request
a_op  in  2  A operation (PUT/BACK/SETPOS/CLEAR)
a_data  in  CW  A char code or position
a_ready  out  1  A transfer accepted this cycle
b_valid, b_op, b_data, b_ready  same as A, for requester B
character  out  [0:CW-1] x [0:NUM_CHARS-1]  committed display array to renderer
cursor  out  POS_W  current write position
busy  out  1  high while in CLEAR state
bad_char  out  1  one-cycle pulse when a PUT code is unsupported

Behaviour:
- Reset (async, rst=1):
  - character[*]=0, shadow[*]=0, cursor=0, dirty=0, busy=0, bad_char=0.
  - FSM=IDLE; round-robin pointer favours A.
  - Mid-CLEAR reset abandons the clear with no residual state.
- FSM states:
  - IDLE: accepts one request per cycle.
  - CLEAR: writes shadow[k]=0 for k=0..NUM_CHARS-1, one cell per cycle (NUM_CHARS cycles), then returns to IDLE; busy=1 throughout.
- Handshake:
  - x_ready is combinational and high only in IDLE, only for the granted requester, and only when that requester's x_valid=1.
  - Transfer = x_valid & x_ready. At most one transfer per cycle.
  - Requesters hold valid/op/data stable until ready.
- Arbitration:
  - Round-robin over 2 requesters. If both are valid, the one not served last wins; a lone valid wins immediately.
  - The pointer updates only on a transfer.
- Ops (all take effect at the accepting edge):
  - PUT(00): if code is 0, 48-57 or 65-90, shadow[cursor]=code; otherwise shadow[cursor]=0 and bad_char pulses next cycle. cursor = (cursor==NUM_CHARS-1) ? 0 : cursor+1.
  - BACK(01): if cursor==0, no-op (dirty unchanged); else cursor-1 and shadow[cursor-1]=0.
  - SETPOS(10): cursor = min(data, NUM_CHARS-1); shadow unchanged; dirty unchanged.
  - CLEAR(11): cursor=0, enter CLEAR; ready low for NUM_CHARS cycles.
- dirty:
  - Set by any shadow-modifying op (PUT, effective BACK, each CLEAR step).
- Commit:
  - When vsync_start=1, dirty=1 and FSM=IDLE, character <= shadow as registered before that edge, and dirty is cleared.
  - A write accepted in the same cycle lands in shadow; set wins, so dirty stays 1 and the write appears at the next vsync.
  - vsync_start during CLEAR: no commit. The commit is deferred to the next vsync after the clear finishes.
- Latency: request to cursor/shadow update is 1 cycle; shadow to screen is at the next eligible vsync.

Decomposition:
- Package text_pkg:
  - NUM_CHARS, CW, POS_W.
  - op_t enum {OP_PUT, OP_BACK, OP_SETPOS, OP_CLEAR}.
  - state_t enum {S_IDLE, S_CLEAR}.
  - Function char_supported(code).
- Sub-module rr_arb2: 2-way round-robin arbiter with valid inputs, a one-hot grant output, and an advance input.

Test Plan:
1. Reset: assert rst mid-cycle -> character all 0, cursor=0, ready=0, busy=0 asynchronously.
2. A PUTs 72,73 (H,I), then vsync_start -> character[0]=72, character[1]=73, cursor=2; before vsync, character is unchanged.
3. A and B valid together for 4 cycles, with A served last -> grants B,A,B,A; exactly one ready per cycle; cursor advances 4.
4. SETPOS 39, PUT 65, PUT 66 -> shadow[39]=65, shadow[0]=66, cursor=1. BACK from cursor 0 -> no change.
5. PUT 35 -> stored 0, bad_char pulses once, cursor increments.
6. CLEAR, then vsync_start on clear cycle 10 -> no commit; busy high for 40 cycles; next vsync commits an all-zero line. PUT in the same cycle as a commit -> visible only after the following vsync.
